// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, oversampled majority voting and
// START/DATA/PARITY/STOP sequencing in front of the deserializer.
//   state  | meaning
//   IDLE   | line idle, waiting for a low level
//   START  | confirming the start bit at its mid-point vote
//   DATA   | shifting voted data bits into the deserializer
//   PARITY | checking the parity bit against the completed word
//   STOP   | checking the stop bit and reporting the frame
module uart_rx_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic [5:0]           prescale,
    input  logic                 par_en,
    input  logic                 par_typ,
    input  logic [DATA_BITS-1:0] p_data,
    output logic                 deser_en,
    output logic [4:0]           edge_cnt,
    output logic                 sampled_bit,
    output logic                 data_valid,
    output logic                 par_err,
    output logic                 stp_err,
    output logic                 busy
);

    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    edge_cnt_q, edge_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          smp0_q, smp0_d;
    logic          smp1_q, smp1_d;
    logic          sampled_bit_q, sampled_bit_d;
    logic          data_valid_q, data_valid_d;
    logic          par_err_q, par_err_d;
    logic          stp_err_q, stp_err_d;

    logic [5:0]    edge_ext;
    logic [5:0]    last_edge;
    logic [5:0]    mid_edge;
    logic          at_last;
    logic          at_smp0;
    logic          at_smp1;
    logic          at_smp2;

    assign edge_ext  = {1'b0, edge_cnt_q};
    assign last_edge = prescale - 6'd1;
    assign mid_edge  = {1'b0, prescale[5:1]};
    assign at_last   = (edge_ext == last_edge);
    assign at_smp0   = (edge_ext == mid_edge - 6'd1);
    assign at_smp1   = (edge_ext == mid_edge);
    assign at_smp2   = (edge_ext == mid_edge + 6'd1);

    // The detection cycle counts as edge 0, so the counter leaves IDLE at 1.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (state_q == IDLE) begin
            edge_cnt_d = rx_in ? 5'd0 : 5'd1;
        end else if (at_last) begin
            edge_cnt_d = 5'd0;
        end else begin
            edge_cnt_d = edge_cnt_q + 5'd1;
        end
    end

    always_comb begin
        smp0_d        = smp0_q;
        smp1_d        = smp1_q;
        sampled_bit_d = sampled_bit_q;
        if (state_q != IDLE) begin
            if (at_smp0) begin
                smp0_d = rx_in;
            end
            if (at_smp1) begin
                smp1_d = rx_in;
            end
            if (at_smp2) begin
                sampled_bit_d = (smp0_q & smp1_q) | (smp0_q & rx_in) | (smp1_q & rx_in);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        data_valid_d = 1'b0;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;
        case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d   = START;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            START: begin
                if (at_last) begin
                    if (sampled_bit_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (at_last) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (at_last) begin
                    par_err_d = sampled_bit_q ^ (^p_data) ^ par_typ;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (at_last) begin
                    stp_err_d    = ~sampled_bit_q;
                    data_valid_d = sampled_bit_q & ~par_err_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sample registers preload the idle line level so a stale vote never reads low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            edge_cnt_q    <= 5'd0;
            bit_cnt_q     <= '0;
            smp0_q        <= 1'b1;
            smp1_q        <= 1'b1;
            sampled_bit_q <= 1'b0;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            edge_cnt_q    <= edge_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            smp0_q        <= smp0_d;
            smp1_q        <= smp1_d;
            sampled_bit_q <= sampled_bit_d;
            data_valid_q  <= data_valid_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
        end
    end

    assign deser_en    = (state_q == DATA);
    assign busy        = (state_q != IDLE);
    assign edge_cnt    = edge_cnt_q;
    assign sampled_bit = sampled_bit_q;
    assign data_valid  = data_valid_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: builds serial line waveforms, predicts outputs per
// cycle from frame-level arithmetic, and models the downstream deserializer.
module tb_uart_rx_ctrl;

    localparam int MAXC = 1024;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       deser_en;
    logic [4:0] edge_cnt;
    logic       sampled_bit;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    uart_rx_ctrl #(.DATA_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .p_data      (p_data),
        .deser_en    (deser_en),
        .edge_cnt    (edge_cnt),
        .sampled_bit (sampled_bit),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_checks;
    int   n_fail;
    int   cyc;
    int   nline;
    logic chk_en;
    int   pre;
    logic line_q[$];

    int   req_busy [MAXC];
    int   req_den  [MAXC];
    int   req_edge [MAXC];
    int   req_dv   [MAXC];
    int   req_pe   [MAXC];
    int   req_se   [MAXC];
    int   req_sbv  [MAXC];
    int   req_sb   [MAXC];
    int   req_pd   [MAXC];
    int   act_busy [MAXC];

    int   first_dv;
    int   first_pe;
    int   first_se;
    int   dv_cnt;
    int   den_cnt;
    int   dv_cyc [4];
    int   dv_dat [4];

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
        end
    endtask

    function automatic int vote(input int i0);
        int a;
        a = int'(line_q[i0]) + int'(line_q[i0 + 1]) + int'(line_q[i0 + 2]);
        return (a >= 2) ? 1 : 0;
    endfunction

    task automatic setup(input int p, input logic pe_en, input logic ptyp);
        pre     = p;
        par_en  = pe_en;
        par_typ = ptyp;
        line_q.delete();
    endtask

    task automatic add_bit(input logic v, input int inv_edge);
        for (int e = 0; e < pre; e++) begin
            line_q.push_back((e == inv_edge) ? ~v : v);
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            line_q.push_back(1'b1);
        end
    endtask

    task automatic add_frame(input logic [7:0] d, input logic par_flip,
                             input logic stop_v, input int inv_edge);
        add_bit(1'b0, -1);
        for (int k = 0; k < 8; k++) begin
            add_bit(d[k], inv_edge);
        end
        if (par_en) begin
            add_bit((^d) ^ par_typ ^ par_flip, -1);
        end
        add_bit(stop_v, -1);
    endtask

    // Frame-level prediction: each frame is located by its falling edge and
    // every output follows from the cycle offset within the frame.
    task automatic build_model();
        int   c, s, h, nb, len, t, cc;
        int   glitch, pe_new, se_new, dv_new, pv, sv;
        int   pe, se;
        logic [7:0] d;
        nline = line_q.size();
        h     = pre / 2;
        pe    = 0;
        se    = 0;
        for (int i = 0; i < MAXC; i++) begin
            req_busy[i] = 0; req_den[i] = 0; req_edge[i] = 0; req_dv[i] = 0;
            req_pe[i] = 0; req_se[i] = 0; req_sbv[i] = 0; req_sb[i] = 0;
            req_pd[i] = 0; act_busy[i] = 0;
        end
        c = 0;
        while (c < nline) begin
            if (line_q[c] == 1'b1) begin
                req_pe[c] = pe;
                req_se[c] = se;
                c++;
            end else begin
                s      = c;
                glitch = vote(s + h - 1);
                nb     = (glitch != 0) ? 1 : (10 + int'(par_en));
                len    = nb * pre;
                d      = 8'h00;
                pe_new = 0;
                se_new = 0;
                dv_new = 0;
                if (glitch == 0) begin
                    for (int k = 0; k < 8; k++) begin
                        d[k] = vote(s + (k + 1) * pre + h - 1) != 0;
                    end
                    if (par_en) begin
                        pv     = vote(s + 9 * pre + h - 1);
                        pe_new = pv ^ int'(^d) ^ int'(par_typ);
                    end
                    sv     = vote(s + (nb - 1) * pre + h - 1);
                    se_new = (sv == 0) ? 1 : 0;
                    dv_new = (sv == 1 && pe_new == 0) ? 1 : 0;
                end
                for (t = 0; t < len; t++) begin
                    cc = s + t;
                    if (cc < nline) begin
                        req_edge[cc] = t % pre;
                        req_busy[cc] = (t > 0) ? 1 : 0;
                        req_den[cc]  = (glitch == 0 && t >= pre && t < 9 * pre) ? 1 : 0;
                        if (t == 0) begin
                            req_pe[cc] = pe;
                            req_se[cc] = se;
                        end else begin
                            req_pe[cc] = (glitch == 0 && par_en && t >= 10 * pre) ? pe_new : 0;
                            req_se[cc] = 0;
                        end
                        if ((t % pre) >= h + 2) begin
                            req_sbv[cc] = 1;
                            req_sb[cc]  = vote(s + (t / pre) * pre + h - 1);
                        end
                    end
                end
                pe = pe_new;
                se = se_new;
                if (s + len < nline) begin
                    req_dv[s + len] = dv_new;
                    req_pd[s + len] = int'(d);
                end
                c = s + len;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && cyc < nline) begin
                chk("busy", int'(busy), req_busy[cyc]);
                chk("deser_en", int'(deser_en), req_den[cyc]);
                chk("edge_cnt", int'(edge_cnt), req_edge[cyc]);
                chk("data_valid", int'(data_valid), req_dv[cyc]);
                chk("par_err", int'(par_err), req_pe[cyc]);
                chk("stp_err", int'(stp_err), req_se[cyc]);
                if (req_sbv[cyc] != 0) begin
                    chk("sampled_bit", int'(sampled_bit), req_sb[cyc]);
                end
                if (req_dv[cyc] != 0) begin
                    chk("p_data", int'(p_data), req_pd[cyc]);
                end
                act_busy[cyc] = busy;
                if (deser_en) den_cnt++;
                if (par_err && first_pe < 0) first_pe = cyc;
                if (stp_err && first_se < 0) first_se = cyc;
                if (data_valid) begin
                    if (first_dv < 0) first_dv = cyc;
                    if (dv_cnt < 4) begin
                        dv_cyc[dv_cnt] = cyc;
                        dv_dat[dv_cnt] = int'(p_data);
                    end
                    dv_cnt++;
                end
            end
        end
    end

    task automatic run(input int abort_at);
        logic sh;
        logic b;
        build_model();
        first_dv = -1; first_pe = -1; first_se = -1; dv_cnt = 0; den_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            dv_cyc[i] = -1;
            dv_dat[i] = -1;
        end
        prescale = 6'(pre);
        chk_en   = 1'b0;
        rst      = 1'b0;
        rx_in    = 1'b1;
        p_data   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        cyc    = 0;
        rx_in  = line_q[0];
        chk_en = 1'b1;
        for (int c = 0; c < nline; c++) begin
            if (c == abort_at) begin
                chk_en = 1'b0;
                #1 rst = 1'b0;
                #1;
                chk("rst_busy", int'(busy), 0);
                chk("rst_deser_en", int'(deser_en), 0);
                chk("rst_edge_cnt", int'(edge_cnt), 0);
                chk("rst_sampled_bit", int'(sampled_bit), 0);
                chk("rst_data_valid", int'(data_valid), 0);
                chk("rst_par_err", int'(par_err), 0);
                chk("rst_stp_err", int'(stp_err), 0);
                break;
            end
            @(negedge clk);
            sh = deser_en && (int'(edge_cnt) == pre - 1);
            b  = sampled_bit;
            @(posedge clk);
            #1;
            if (sh) p_data = {b, p_data[7:1]};
            cyc = c + 1;
            if (c + 1 < nline) rx_in = line_q[c + 1];
        end
        chk_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        p_data   = 8'h00;
        chk_en   = 1'b0;
        cyc      = 0;
        nline    = 0;
        pre      = 8;

        // good frame with even parity
        setup(8, 1'b1, 1'b0);
        add_frame(8'hA5, 1'b0, 1'b1, -1);
        add_idle(16);
        run(-1);
        chk("s1_dv_cycle", first_dv, 88);
        chk("s1_dv_count", dv_cnt, 1);
        chk("s1_data", dv_dat[0], 'hA5);
        chk("s1_par_err_never", first_pe, -1);

        // bad parity, then a good frame clears the flag
        setup(8, 1'b1, 1'b0);
        add_frame(8'hA5, 1'b1, 1'b1, -1);
        add_idle(4);
        add_frame(8'h3C, 1'b0, 1'b1, -1);
        add_idle(16);
        run(-1);
        chk("s2_par_err_cycle", first_pe, 80);
        chk("s2_dv_count", dv_cnt, 1);
        chk("s2_dv_cycle", first_dv, 180);
        chk("s2_data", dv_dat[0], 'h3C);

        // stop error
        setup(16, 1'b0, 1'b0);
        add_frame(8'h0F, 1'b0, 1'b0, -1);
        add_idle(24);
        run(-1);
        chk("s3_stp_err_cycle", first_se, 160);
        chk("s3_dv_count", dv_cnt, 0);

        // glitch rejection
        setup(16, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) line_q.push_back(1'b0);
        add_idle(40);
        run(-1);
        chk("s4_busy_c15", int'(act_busy[15]), 1);
        chk("s4_busy_c16", int'(act_busy[16]), 0);
        chk("s4_deser_en_count", den_cnt, 0);
        chk("s4_flags", first_pe + first_se, -2);

        // majority vote and back-to-back frames
        setup(32, 1'b0, 1'b0);
        add_frame(8'h55, 1'b0, 1'b1, 15);
        add_frame(8'hAA, 1'b0, 1'b1, 15);
        add_idle(40);
        run(-1);
        chk("s5_dv_count", dv_cnt, 2);
        chk("s5_dv0_cycle", dv_cyc[0], 320);
        chk("s5_dv1_cycle", dv_cyc[1], 640);
        chk("s5_data0", dv_dat[0], 'h55);
        chk("s5_data1", dv_dat[1], 'hAA);

        // reset during data bit 4, then a normal frame
        setup(8, 1'b0, 1'b0);
        add_frame(8'h5A, 1'b0, 1'b1, -1);
        add_idle(16);
        run(43);
        chk("s6_dv_before_abort", dv_cnt, 0);

        setup(8, 1'b0, 1'b0);
        add_frame(8'h5A, 1'b0, 1'b1, -1);
        add_idle(16);
        run(-1);
        chk("s7_dv_cycle", first_dv, 80);
        chk("s7_data", dv_dat[0], 'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART RX path, directly upstream of the deserializer. Tracks oversampled edges and bit positions, majority-votes each bit, sequences START/DATA/PARITY/STOP, and drives `deser_en`, `edge_cnt` and `sampled_bit` into the deserializer. It consumes the deserializer's `p_data` to check parity, flags stop errors, and pulses `data_valid` for each good frame.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `clk`  in  1  system clock (oversampling clock).
- `rst`  in  1  reset; asynchronous, active-low.
- `rx_in`  in  1  serial line, idle high; already synchronized to `clk` at top level.
- `prescale`  in  6  oversampling ratio; legal values 8, 16, 32.
- `par_en`  in  1  1 = parity bit present.
- `par_typ`  in  1  0 = even, 1 = odd parity.
- `p_data`  in  8  parallel word from the deserializer.
- `deser_en`  out  1  shift enable to the deserializer.
- `edge_cnt`  out  5  edge index within the current bit, 0..prescale-1.
- `sampled_bit`  out  1  majority-voted value of the current bit.
- `data_valid`  out  1  one-cycle pulse: frame received with no error.
- `par_err`  out  1  parity error of the last frame.
- `stp_err`  out  1  stop error of the last frame.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Edge counter:
  - Holds 0 in IDLE.
  - Increments in the IDLE cycle where `rx_in`=0 (the detection cycle, edge 0), then every cycle outside IDLE.
  - Wraps from prescale-1 to 0.
- Bit counter: 0..DATA_BITS-1. Increments at each DATA-state wrap. Cleared on entering DATA.
- Sampler:
  - Captures `rx_in` at edges prescale/2-1, prescale/2 and prescale/2+1.
  - At edge prescale/2+1, registers the majority of the three into `sampled_bit`.
  - `sampled_bit` holds its value otherwise.
- IDLE -> START when `rx_in`=0.
  - On this transition, clear `par_err` and `stp_err`.
- START, at edge prescale-1:
  - `sampled_bit`=1 is a glitch: go to IDLE. No flags change and no `data_valid`.
  - Otherwise go to DATA.
- DATA:
  - `deser_en`=1 for every cycle in DATA.
  - At edge prescale-1 with bit counter = DATA_BITS-1, go to PARITY if `par_en`, else STOP.
- PARITY, at edge prescale-1:
  - Set `par_err` = `sampled_bit` XOR (^`p_data`) XOR `par_typ`.
  - Go to STOP.
  - `p_data` is complete throughout PARITY, because the last shift happens on the final DATA edge.
- STOP, at edge prescale-1:
  - Set `stp_err` = ~`sampled_bit`.
  - Pulse `data_valid` when `sampled_bit`=1 and `par_err`=0. With `par_en`=0, only the stop bit is checked.
  - Go to IDLE.
- Error frames: no `data_valid`. Flags stay set until the next START entry.
- `prescale` changes only while `busy`=0. Behaviour on a change while busy is undefined, and the bench does not exercise it.

## Timing
- Reset values:
  - All outputs 0; `busy` 0.
  - State IDLE; edge and bit counters 0; the sample registers preload 1 (line-idle level).
- Asserting `rst` mid-frame aborts the frame: no `data_valid`, flags cleared.
- Output registration:
  - `data_valid`, `par_err` and `stp_err` are registered outputs.
  - `deser_en` and `busy` decode the current state.
  - `edge_cnt` is the counter register.
- Cycle numbering: the detection cycle is cycle 0.
  - Frame length N = (1 + DATA_BITS + `par_en` + 1) × prescale.
  - `data_valid` is high in cycle N, for exactly 1 cycle.
- Back-to-back frames:
  - The cycle after the last STOP edge is IDLE.
  - A start bit low in that cycle is detected with zero gap, so frames can run continuously.
- The deserializer shifts at edge_cnt = prescale-1 in DATA. `sampled_bit` is stable from edge prescale/2+2, so it is valid at that point for every legal prescale.

## Test plan
- Good frame with parity: prescale=8, `par_en`=1, `par_typ`=0, frame 0xA5 with parity bit 0 and stop 1 → `p_data`=0xA5, `data_valid` high in cycle 88 only, `par_err`=0, `stp_err`=0.
- Bad parity: same settings, parity bit driven 1 → `par_err`=1 from cycle 80, no `data_valid`. A following good frame 0x3C clears `par_err` and pulses `data_valid`.
- Stop error: prescale=16, `par_en`=0, frame 0x0F with stop bit 0 → `stp_err`=1 at cycle 160, no `data_valid`.
- Glitch rejection: prescale=16, `rx_in` low for 3 cycles, then high → START returns to IDLE at cycle 15, `deser_en` never asserted, flags unchanged.
- Majority vote and back-to-back frames: prescale=32, one-cycle inversion at edge 15 of each data bit, frames 0x55 then 0xAA with no idle gap, `par_en`=0 → two `data_valid` pulses 320 cycles apart with correct data.
- Reset mid-frame: assert `rst` during DATA bit 4 → all outputs 0 immediately, state IDLE. A following frame is received normally.
